dbf_chan_dyn: RTL and testbench
===============================

# dbf_chan_dyn

Parametrised single-channel receive beamformer datapath with dynamic focusing: it buffers incoming echo samples in a circular delay line, applies a per-focal-zone coarse delay read from an internally loaded LUT, multiplies by the apodisation weight, and emits a rounded, saturated channel contribution to the summing tree. One instance sits per transducer channel between the ADC front end and the beam adder, and replaces the fixed per-channel coarse-delay blocks with a single generic module.

## Interface
- INPUT_WD, 14, signed echo sample width
- APO_WD, 16, signed apodisation weight width
- OUT_WD, 32, signed output width
- DLY_WD, 8, coarse delay width; buffer depth = 2^DLY_WD samples
- ADDR_WD, 10, LUT address width; LUT holds 2^ADDR_WD zone entries
- ZONE_SHIFT, 4, log2 of samples per focal zone
- LINE_LEN, 4096, samples per receive line
- PROD_SHIFT, 0, arithmetic right shift applied to the product before rounding
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_en  in  1  high during transmit; samples ignored, an active line aborts
- start  in  1  one-cycle pulse, begins a receive line
- ch_in  in  INPUT_WD  signed sample, valid every cycle tx_en is low
- apo_din  in  APO_WD  signed weight, aligned with ch_in
- lut_addr  in  ADDR_WD  LUT write address
- lut_we  in  1  LUT write strobe
- lut_din  in  DLY_WD (DLY_WD+1 with DBF_HALF_INTERP_EN)  delay entry
- dout  out  OUT_WD  signed channel output
- dout_valid  out  1  dout qualifier
- busy  out  1  high while in RUN

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE → RUN: start=1 and tx_en=0. Clears sample counter n and write pointer wp.
- In RUN each cycle: ch_in written to buffer[wp]; wp wraps modulo 2^DLY_WD; n increments.
- RUN → IDLE: n reaches LINE_LEN-1 (last sample accepted), or tx_en=1 (abort; no further samples accepted; in-flight pipeline stages drain and complete).
- start in RUN restarts the line: n and wp cleared the same cycle, that cycle's sample is n=0.
- Zone index z = min(n >> ZONE_SHIFT, 2^ADDR_WD-1); delay d = LUT[z].
- Delayed sample = buffer entry written d samples earlier; d=0 returns the current sample (write-through bypass). If d > n, delayed sample = 0.
- LUT writes honoured only in IDLE; lut_we in RUN is ignored. LUT contents are not cleared by reset.
- p = delayed sample × apo_din (full INPUT_WD+APO_WD signed); q = p >>> PROD_SHIFT with round-half-up on the discarded bits; dout = q saturated to OUT_WD (sign-extended if narrower).

## Timing
- Reset values: dout=0, dout_valid=0, busy=0, state IDLE, n=0, wp=0.
- Latency 3 cycles: sample accepted at cycle t produces dout/dout_valid at t+3 (4 with DBF_HALF_INTERP_EN).
- dout_valid high exactly one cycle per accepted sample; when it is low, dout=0.
- busy rises the cycle after start is sampled and falls the cycle after the last sample or abort.
- Reset mid-line: outputs go to reset values immediately; pipeline contents are discarded.

## Configuration
- DBF_HALF_INTERP_EN defined: lut_din is DLY_WD+1 bits; the LSB is a half-sample flag, the upper bits are d. When the flag is set, delayed sample = (x[d]+x[d+1]) >>> 1, with round-half-up, using 0 for any term older than n. Adds one pipeline stage.
- Undefined: integer delay only; the lut_din width and latency are as above.

## Test plan
- Load LUT all 0, apo=16384, PROD_SHIFT=14, ramp ch_in=0,1,2…: dout=0,1,2… at +3 cycles, 4096 valids, then busy=0.
- LUT[0]=5, ZONE_SHIFT=4: first 5 outputs 0, output 5 = ch_in[0]; at n=16, LUT[1]=2 gives dout=ch_in[14].
- ch_in=-8192, apo=-32768, PROD_SHIFT=0, OUT_WD=16: dout saturates to 32767.
- tx_en raised at n=100: 101 valids total, busy drops, a new start accepts a fresh line from n=0.
- lut_we during RUN with lut_din=7: LUT entry unchanged, verified on the next line.
- DBF_HALF_INTERP_EN, entry d=3 with half flag set, ramp input: dout = n-3.5 rounded up = n-3, latency 4.

Source files
------------

// File: rtl/dbf_chan_dyn.sv
// Receive-beamformer channel: focal-zone LUT coarse delay over a circular sample buffer, apodise, round, saturate.
// Latency 3 (4 with DBF_HALF_INTERP_EN for half-sample interpolation); no backpressure, one sample per cycle in RUN.
module dbf_chan_dyn #(
   parameter int INPUT_WD   = 14,
   parameter int APO_WD     = 16,
   parameter int OUT_WD     = 32,
   parameter int DLY_WD     = 8,
   parameter int ADDR_WD    = 10,
   parameter int ZONE_SHIFT = 4,
   parameter int LINE_LEN   = 4096,
   parameter int PROD_SHIFT = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tx_en,
   input  logic                       start,
   input  logic signed [INPUT_WD-1:0] ch_in,
   input  logic signed [APO_WD-1:0]   apo_din,
   input  logic [ADDR_WD-1:0]         lut_addr,
   input  logic                       lut_we,
`ifdef DBF_HALF_INTERP_EN
   input  logic [DLY_WD:0]            lut_din,
`else
   input  logic [DLY_WD-1:0]          lut_din,
`endif
   output logic signed [OUT_WD-1:0]   dout,
   output logic                       dout_valid,
   output logic                       busy
);
`ifdef DBF_HALF_INTERP_EN
   localparam int LUT_WD = DLY_WD + 1;
`else
   localparam int LUT_WD = DLY_WD;
`endif
   localparam int N_WD = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int P_WD = INPUT_WD + APO_WD;
   localparam int WW   = P_WD + OUT_WD + 2;
   localparam int ZMAX = (1 << ADDR_WD) - 1;
   localparam logic signed [WW-1:0] RND     = WW'((64'd1 << PROD_SHIFT) >> 1);
   localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
   localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_WD+1){1'b1}}, {(OUT_WD-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   state_t state, state_nxt;

   logic [N_WD-1:0]            n_q, n_cur;
   logic [DLY_WD-1:0]          wp_q, wp_cur;
   logic                       accept;
   logic signed [INPUT_WD-1:0] dly_mem [1 << DLY_WD];
   logic [LUT_WD-1:0]          lut_mem [1 << ADDR_WD];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && !tx_en) state_nxt = RUN;
         RUN: begin
            if (tx_en)                               state_nxt = IDLE;
            else if (n_cur == N_WD'(LINE_LEN - 1))  state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == RUN);
      accept = (state == RUN) && !tx_en;
   end

   // A restart in RUN makes the current cycle's sample n=0.
   assign n_cur  = (state == RUN && start) ? '0 : n_q;
   assign wp_cur = (state == RUN && start) ? '0 : wp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q  <= '0;
         wp_q <= '0;
      end else if (state == IDLE) begin
         if (start && !tx_en) begin
            n_q  <= '0;
            wp_q <= '0;
         end
      end else if (accept) begin
         n_q  <= n_cur + N_WD'(1);
         wp_q <= wp_cur + DLY_WD'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)                   dly_mem[wp_cur]   <= ch_in;
      if (lut_we && state == IDLE)  lut_mem[lut_addr] <= lut_din;
   end

   logic [31:0]                zone_full;
   logic [ADDR_WD-1:0]         zone;
   logic [LUT_WD-1:0]          lut_q;
   logic [DLY_WD-1:0]          d, rd_a;
   logic signed [INPUT_WD-1:0] x_a;

   always_comb begin
      zone_full = 32'(n_cur) >> ZONE_SHIFT;
      zone      = (zone_full > 32'(ZMAX)) ? ADDR_WD'(ZMAX) : ADDR_WD'(zone_full);
      lut_q     = lut_mem[zone];
      d         = lut_q[LUT_WD-1:LUT_WD-DLY_WD];
      rd_a      = wp_cur - d;
      // Zero delay bypasses the buffer; taps older than the line start read as zero.
      if (d == '0)                    x_a = ch_in;
      else if (32'(d) > 32'(n_cur))   x_a = '0;
      else                            x_a = dly_mem[rd_a];
   end

   logic                       v1_d, v1_q, v2_q;
   logic signed [INPUT_WD-1:0] x1_d, x1_q;
   logic signed [APO_WD-1:0]   a1_d, a1_q;
   logic signed [P_WD-1:0]     prod_q;

`ifdef DBF_HALF_INTERP_EN
   logic [DLY_WD:0]            d1;
   logic [DLY_WD-1:0]          rd_b;
   logic signed [INPUT_WD-1:0] x_b, xa_q, xb_q;
   logic signed [APO_WD-1:0]   apo0_q;
   logic                       v0_q, h_q;
   logic signed [INPUT_WD:0]   pair_sum;

   always_comb begin
      d1   = {1'b0, d} + (DLY_WD+1)'(1);
      rd_b = wp_cur - d1[DLY_WD-1:0];
      x_b  = (32'(d1) > 32'(n_cur)) ? '0 : dly_mem[rd_b];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q   <= 1'b0;
         h_q    <= 1'b0;
         xa_q   <= '0;
         xb_q   <= '0;
         apo0_q <= '0;
      end else begin
         v0_q   <= accept;
         h_q    <= lut_q[0];
         xa_q   <= x_a;
         xb_q   <= x_b;
         apo0_q <= apo_din;
      end
   end

   // (a + b + 1) >>> 1 is round-half-up of the midpoint and always fits INPUT_WD.
   always_comb begin
      pair_sum = {xa_q[INPUT_WD-1], xa_q} + {xb_q[INPUT_WD-1], xb_q} + (INPUT_WD+1)'(1);
      x1_d     = h_q ? pair_sum[INPUT_WD:1] : xa_q;
      a1_d     = apo0_q;
      v1_d     = v0_q;
   end
`else
   always_comb begin
      x1_d = x_a;
      a1_d = apo_din;
      v1_d = accept;
   end
`endif

   logic signed [P_WD-1:0] x_ext, a_ext;
   logic signed [WW-1:0]   prod_w, q_w, sat_w;

   always_comb begin
      x_ext  = $signed({{APO_WD{x1_q[INPUT_WD-1]}}, x1_q});
      a_ext  = $signed({{INPUT_WD{a1_q[APO_WD-1]}}, a1_q});
      prod_w = $signed({{(WW-P_WD){prod_q[P_WD-1]}}, prod_q});
      q_w    = (prod_w + RND) >>> PROD_SHIFT;
      if (q_w > SAT_MAX)      sat_w = SAT_MAX;
      else if (q_w < SAT_MIN) sat_w = SAT_MIN;
      else                    sat_w = q_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         x1_q       <= '0;
         a1_q       <= '0;
         v2_q       <= 1'b0;
         prod_q     <= '0;
         dout_valid <= 1'b0;
         dout       <= '0;
      end else begin
         v1_q       <= v1_d;
         x1_q       <= x1_d;
         a1_q       <= a1_d;
         v2_q       <= v1_q;
         prod_q     <= x_ext * a_ext;
         dout_valid <= v2_q;
         dout       <= v2_q ? sat_w[OUT_WD-1:0] : '0;
      end
   end
endmodule

// File: tb/tb_dbf_chan_dyn.sv
// Bench for dbf_chan_dyn: directed line scenarios with random samples, checked each cycle against a line-level model.
module tb_dbf_chan_dyn;
   localparam int INPUT_WD   = 14;
   localparam int APO_WD     = 16;
   localparam int OUT_WD     = 16;
   localparam int DLY_WD     = 6;
   localparam int ADDR_WD    = 5;
   localparam int ZONE_SHIFT = 4;
   localparam int LINE_LEN   = 600;
   localparam int PROD_SHIFT = 12;
   localparam int NCYC       = 4096;
   localparam int NZONE      = 1 << ADDR_WD;

   logic                       clk = 1'b0;
   logic                       rst_n, tx_en, start, lut_we;
   logic signed [INPUT_WD-1:0] ch_in;
   logic signed [APO_WD-1:0]   apo_din;
   logic [ADDR_WD-1:0]         lut_addr;
   logic [DLY_WD-1:0]          lut_din;
   logic signed [OUT_WD-1:0]   dout;
   logic                       dout_valid, busy;

   always #5 clk = ~clk;

   dbf_chan_dyn #(
      .INPUT_WD(INPUT_WD), .APO_WD(APO_WD), .OUT_WD(OUT_WD), .DLY_WD(DLY_WD),
      .ADDR_WD(ADDR_WD), .ZONE_SHIFT(ZONE_SHIFT), .LINE_LEN(LINE_LEN), .PROD_SHIFT(PROD_SHIFT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start), .ch_in(ch_in), .apo_din(apo_din),
      .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
      .dout(dout), .dout_valid(dout_valid), .busy(busy)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int k        = 0;
   int vld_cnt  = 0;

   logic                     exp_v [NCYC];
   logic                     exp_b [NCYC];
   logic signed [OUT_WD-1:0] exp_d [NCYC];
   int                       m_lut [NZONE];
   int                       hist  [LINE_LEN];
   bit                       m_run;
   int                       m_n;

   task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, k, act, exp);
      end
   endtask

   // Expected output: delayed sample times weight, rounded half-up at PROD_SHIFT, clipped to OUT_WD.
   function automatic logic signed [31:0] model_out(input int x, input int a);
      longint p, q;
      p = longint'(x) * longint'(a);
      q = (p + ((longint'(1) <<< PROD_SHIFT) / 2)) >>> PROD_SHIFT;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return 32'(q);
   endfunction

   task automatic tick();
      int z, d, x;
      if (!m_run) begin
         if (lut_we) m_lut[lut_addr] = int'(lut_din);
         if (start && !tx_en) begin
            m_run = 1'b1;
            m_n   = 0;
         end
      end else if (tx_en) begin
         m_run = 1'b0;
      end else begin
         if (start) m_n = 0;
         hist[m_n] = int'(ch_in);
         z = m_n >> ZONE_SHIFT;
         if (z > NZONE - 1) z = NZONE - 1;
         d = m_lut[z];
         x = (d > m_n) ? 0 : hist[m_n - d];
         exp_v[k+3] = 1'b1;
         exp_d[k+3] = OUT_WD'(model_out(x, int'(apo_din)));
         if (m_n == LINE_LEN - 1) m_run = 1'b0;
         else                     m_n++;
      end
      exp_b[k+1] = m_run;
      @(posedge clk);
      #1;
      k++;
      if (dout_valid === 1'b1) vld_cnt++;
      check("busy", busy, exp_b[k]);
      check("dout_valid", dout_valid, exp_v[k]);
      check("dout", dout, exp_d[k]);
   endtask

   task automatic lut_write(input int a, input int v);
      lut_we   = 1'b1;
      lut_addr = ADDR_WD'(a);
      lut_din  = DLY_WD'(v);
      tick();
      lut_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rand_samples(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         ch_in   = INPUT_WD'($urandom);
         apo_din = APO_WD'($urandom);
         tick();
      end
   endtask

   task automatic abort_line();
      tx_en = 1'b1;
      tick();
      tx_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NCYC; i++) begin
         exp_v[i] = 1'b0;
         exp_b[i] = 1'b0;
         exp_d[i] = '0;
      end
      m_run = 1'b0;
      m_n   = 0;
      rst_n = 1'b0; tx_en = 1'b0; start = 1'b0; lut_we = 1'b0;
      ch_in = '0; apo_din = '0; lut_addr = '0; lut_din = '0;
      #3;
      check("rst_dout", dout, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Unity-gain ramp with zero delay: output tracks input, one valid per sample.
      for (int a = 0; a < NZONE; a++) lut_write(a, 0);
      apo_din = 16'sd4096;
      vld_cnt = 0;
      pulse_start();
      for (int i = 0; i < LINE_LEN; i++) begin
         ch_in = INPUT_WD'(i);
         tick();
      end
      repeat (5) tick();
      check("ramp_valid_count", vld_cnt, LINE_LEN);

      // Per-zone delays incl. d > n, maximum depth, and clamped last zone.
      lut_write(0, 5);
      lut_write(1, 2);
      lut_write(2, 63);
      lut_write(5, 63);
      for (int a = 6; a < NZONE; a++) lut_write(a, $urandom_range(0, 63));
      lut_write(NZONE - 1, 17);
      vld_cnt = 0;
      pulse_start();
      rand_samples(LINE_LEN);
      repeat (5) tick();
      check("zone_valid_count", vld_cnt, LINE_LEN);

      // Saturation both ways, abort after sample n=100, and start ignored while tx_en.
      for (int a = 0; a < 8; a++) lut_write(a, 0);
      vld_cnt = 0;
      pulse_start();
      for (int i = 0; i < 101; i++) begin
         ch_in   = (i < 4) ? -14'sd8192 : (i < 8) ? 14'sd8191 : INPUT_WD'($urandom);
         apo_din = (i < 8) ? -16'sd32768 : APO_WD'($urandom);
         tick();
      end
      abort_line();
      repeat (5) tick();
      check("abort_valid_count", vld_cnt, 101);
      tx_en = 1'b1;
      pulse_start();
      tx_en = 1'b0;
      tick();

      // LUT writes in RUN are dropped; mid-line restart; next line uses the old entry.
      pulse_start();
      lut_we = 1'b1; lut_addr = '0; lut_din = 6'd7;
      rand_samples(10);
      start = 1'b1;
      rand_samples(1);
      start = 1'b0;
      rand_samples(30);
      lut_we = 1'b0;
      abort_line();
      pulse_start();
      rand_samples(40);
      abort_line();
      repeat (4) tick();

      // Reset mid-line clears outputs at once and discards the pipeline; LUT survives.
      pulse_start();
      rand_samples(30);
      rst_n = 1'b0;
      #1;
      check("midrst_dout", dout, 0);
      check("midrst_dout_valid", dout_valid, 0);
      check("midrst_busy", busy, 0);
      for (int i = k; i < NCYC; i++) begin
         exp_v[i] = 1'b0;
         exp_b[i] = 1'b0;
         exp_d[i] = '0;
      end
      m_run = 1'b0;
      @(posedge clk);
      #1;
      k++;
      rst_n = 1'b1;
      tick();
      vld_cnt = 0;
      pulse_start();
      rand_samples(20);
      abort_line();
      repeat (5) tick();
      check("post_reset_valid_count", vld_cnt, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
